ssk_l3_cmd_issuer: RTL
======================

// Module: ssk_l3_cmd_issuer
// PURPOSE
//  L3-side initiator for the session-key core command interface. Parses a 5-byte command
//  header from the SPI byte receiver, issues cmd_en/cmd_op/cmd_extend/wr_size to the core,
//  packs write payload bytes into 32-bit words on wr_en, then returns one status byte to
//  the SPI transmitter. Sits between the SPI byte layer and the session-key core.
// PARAMETERS
//  TIMEOUT_CYC  16'd4096  response-wait limit in clk cycles (used only with the macro)
//  STS_RD_OK    8'h80     status byte returned when the core grants a read (rd_open)
//  STS_TMO      8'hFF     status byte returned on response timeout
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset: synchronous, active-low
//  clr_ssk     in   1   abort: return to IDLE next cycle
//  ss_expire   in   1   abort: same effect as clr_ssk
//  rx_valid    in   1   SPI rx byte valid
//  rx_data     in   8   SPI rx byte
//  rx_rdy      out  1   byte accepted when rx_valid & rx_rdy
//  cmd_rdy     in   1   core ready for a command
//  cmd_en      out  1   one-cycle command strobe
//  cmd_op      out  8   header byte 0
//  cmd_extend  out  16  header bytes 1 (MSB) and 2
//  wr_size     out  16  header bytes 3 (MSB) and 4; payload byte count
//  wr_open     in   1   core accepted a write
//  rd_open     in   1   core granted a read
//  wr_en       out  1   one-cycle payload word strobe
//  wr_data     out  32  payload word, first byte in [7:0]
//  resp_done   in   1   core response strobe
//  resp_err    in   2   core error code, valid with resp_done
//  tx_valid    out  1   status byte valid, held until tx_rdy
//  tx_data     out  8   status byte
//  tx_rdy      in   1   transmitter accepts status byte
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=HDR, all outputs 0, header regs 0, byte index 0.
//  HDR: rx_rdy=1; 5 bytes fill op, ext[15:8], ext[7:0], size[15:8], size[7:0]; after
//   byte 5 go to ISSUE. cmd_op/cmd_extend/wr_size are registered and held stable from
//   ISSUE until the next return to HDR.
//  ISSUE: rx_rdy=0; when cmd_rdy=1, cmd_en=1 for exactly one cycle -> WAIT_OPEN.
//  WAIT_OPEN: wr_open -> PAYLOAD (wr_size!=0) or WAIT_RESP (wr_size==0);
//   rd_open -> STATUS with STS_RD_OK; resp_done -> STATUS with {6'b0,resp_err}.
//  PAYLOAD: rx_rdy=1 while wr_en is not pending; each byte goes to lane idx[1:0] of the
//   word, rem-=1. On lane 3 or rem==1, wr_en=1 next cycle with the word; unused upper
//   lanes are 0, then clear the word. Pulse count = ceil(wr_size/4). After the last word
//   -> WAIT_RESP. rx_rdy=0 in the wr_en cycle (no byte is lost or merged).
//  WAIT_RESP: resp_done -> STATUS with {6'b0,resp_err}; rd_open/wr_open ignored.
//  STATUS: tx_valid=1 with tx_data held; on tx_valid & tx_rdy -> HDR and clear the index.
//  Latency: header byte 5 -> cmd_en = 1 cycle when cmd_rdy is already high.
//  Abort: clr_ssk|ss_expire -> HDR next cycle from any state; it has priority over every
//   other event in the same cycle. Partial header/word discarded; no status byte sent;
//   cmd_en/wr_en/tx_valid forced 0.
//  rx bytes offered in ISSUE/WAIT_OPEN/WAIT_RESP/STATUS are back-pressured (rx_rdy=0).
//  Simultaneous wr_open and resp_done in WAIT_OPEN: resp_done wins (error path).
// CONFIGURATION
//  SSK_ISSUER_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_OPEN and WAIT_RESP and
//   clears on state entry. When it reaches TIMEOUT_CYC -> STATUS with STS_TMO. A
//   resp_done in that same cycle wins over the timeout.
//  Not defined: no counter; WAIT_OPEN/WAIT_RESP wait indefinitely (abort only).
// TESTING
//  Hdr 12 00 00 00 06, payload 11..66, core wr_open then resp_done err 0 -> wr_data
//   0x44332211 then 0x00006655, 2 wr_en pulses, status 0x00.
//  Hdr 03 00 10 00 00, core rd_open -> cmd_en one cycle, status 0x80, no wr_en.
//  Hdr 21 00 00 00 00, core resp_done err 2'b01 -> status 0x01.
//  Hdr 12 00 00 00 30, core resp_done err 2'b10 -> status 0x02, no payload accepted.
//  clr_ssk after 3 payload bytes -> HDR next cycle, no wr_en, no tx_valid; next header ok.
//  Macro on, TIMEOUT_CYC=16, core silent after cmd_en -> status 0xFF after 16 cycles.

Source files
------------

// File: rtl/ssk_l3_cmd_issuer.sv
// ---------------------------------------------------------------------------
// ssk_l3_cmd_issuer
// L3-side initiator for the session-key core command interface.
// Collects a 5-byte command header from the SPI byte receiver, strobes the
// command into the core, packs write payload bytes into 32-bit words and
// finally returns one status byte to the SPI transmitter.
//
// Optional feature macro: SSK_ISSUER_TIMEOUT_EN
//   defined   : response-wait timeout of TIMEOUT_CYC cycles, status STS_TMO
//   undefined : WAIT_OPEN / WAIT_RESP wait until a core event or an abort
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   clr_ssk, ss_expire      abort to header parsing (highest priority)
//   rx_valid/rx_data/rx_rdy SPI receive byte handshake
//   cmd_rdy/cmd_en          core command handshake (cmd_en is a 1-cycle strobe)
//   cmd_op/cmd_extend/wr_size  registered header fields
//   wr_open/rd_open         core grants for write / read
//   wr_en/wr_data           payload word strobe, first byte in [7:0]
//   resp_done/resp_err      core response strobe and error code
//   tx_valid/tx_data/tx_rdy SPI transmit status-byte handshake
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ssk_l3_cmd_issuer #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096,
  parameter logic [7:0]  STS_RD_OK   = 8'h80,
  parameter logic [7:0]  STS_TMO     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_ssk,
  input  logic        ss_expire,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rdy,
  input  logic        cmd_rdy,
  output logic        cmd_en,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_extend,
  output logic [15:0] wr_size,
  input  logic        wr_open,
  input  logic        rd_open,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        resp_done,
  input  logic [1:0]  resp_err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy
);

  typedef enum logic [2:0] {
    ST_HDR       = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_OPEN = 3'd2,
    ST_PAYLOAD   = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_STATUS    = 3'd5
  } state_e;

  state_e      state_r;
  logic [2:0]  idx_r;    // header byte index in HDR, payload lane (bits [1:0]) in PAYLOAD
  logic [15:0] rem_r;    // payload bytes still to be received
  logic [31:0] word_r;   // partially packed payload word
  logic [31:0] word_s;   // word_r with the current rx byte merged in
  logic        rx_hs_s;
  logic        abort_s;

`ifdef SSK_ISSUER_TIMEOUT_EN
  logic [15:0] tmo_r;
  logic        tmo_hit_s;
`else
  logic        unused_cfg_s;
  assign unused_cfg_s = ^{TIMEOUT_CYC, STS_TMO};
`endif

  // Core error code widened to a status byte.
  function automatic logic [7:0] err_status(input logic [1:0] err);
    return {6'b000000, err};
  endfunction

  assign rx_hs_s = rx_valid & rx_rdy;
  assign abort_s = clr_ssk | ss_expire;

`ifdef SSK_ISSUER_TIMEOUT_EN
  assign tmo_hit_s = (tmo_r == (TIMEOUT_CYC - 16'd1));
`endif

  // Merge the incoming payload byte into its lane of the word being packed.
  always_comb begin
    word_s = word_r;
    case (idx_r[1:0])
      2'd0:    word_s[7:0]   = rx_data;
      2'd1:    word_s[15:8]  = rx_data;
      2'd2:    word_s[23:16] = rx_data;
      2'd3:    word_s[31:24] = rx_data;
      default: word_s        = word_r;
    endcase
  end

  // Command sequencer: header parse, issue, payload packing, status return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_HDR;
      idx_r      <= 3'd0;
      rem_r      <= 16'd0;
      word_r     <= 32'd0;
      rx_rdy     <= 1'b0;
      cmd_en     <= 1'b0;
      cmd_op     <= 8'd0;
      cmd_extend <= 16'd0;
      wr_size    <= 16'd0;
      wr_en      <= 1'b0;
      wr_data    <= 32'd0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'd0;
`ifdef SSK_ISSUER_TIMEOUT_EN
      tmo_r      <= 16'd0;
`endif
    end else if (abort_s) begin
      // rx_rdy drops so no byte is taken while an abort is still asserted.
      state_r  <= ST_HDR;
      idx_r    <= 3'd0;
      word_r   <= 32'd0;
      rx_rdy   <= 1'b0;
      cmd_en   <= 1'b0;
      wr_en    <= 1'b0;
      tx_valid <= 1'b0;
`ifdef SSK_ISSUER_TIMEOUT_EN
      tmo_r    <= 16'd0;
`endif
    end else begin
      cmd_en <= 1'b0;
      wr_en  <= 1'b0;
`ifdef SSK_ISSUER_TIMEOUT_EN
      // Counter restarts from zero on every entry to a wait state.
      if ((state_r != ST_WAIT_OPEN) && (state_r != ST_WAIT_RESP)) begin
        tmo_r <= 16'd0;
      end
`endif
      case (state_r)
        ST_HDR: begin
          rx_rdy <= 1'b1;
          if (rx_hs_s) begin
            case (idx_r)
              3'd0:    cmd_op           <= rx_data;
              3'd1:    cmd_extend[15:8] <= rx_data;
              3'd2:    cmd_extend[7:0]  <= rx_data;
              3'd3:    wr_size[15:8]    <= rx_data;
              3'd4:    wr_size[7:0]     <= rx_data;
              default: cmd_op           <= cmd_op;
            endcase
            if (idx_r == 3'd4) begin
              idx_r  <= 3'd0;
              rx_rdy <= 1'b0;
              // Skip ISSUE when the core is already ready: one-cycle latency.
              if (cmd_rdy) begin
                cmd_en  <= 1'b1;
                state_r <= ST_WAIT_OPEN;
              end else begin
                state_r <= ST_ISSUE;
              end
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end

        ST_ISSUE: begin
          rx_rdy <= 1'b0;
          if (cmd_rdy) begin
            cmd_en  <= 1'b1;
            state_r <= ST_WAIT_OPEN;
          end
        end

        ST_WAIT_OPEN: begin
          rx_rdy <= 1'b0;
          // resp_done outranks the grants so an error always reaches the host.
          if (resp_done) begin
            tx_valid <= 1'b1;
            tx_data  <= err_status(resp_err);
            state_r  <= ST_STATUS;
          end else if (rd_open) begin
            tx_valid <= 1'b1;
            tx_data  <= STS_RD_OK;
            state_r  <= ST_STATUS;
          end else if (wr_open) begin
            if (wr_size != 16'd0) begin
              rem_r   <= wr_size;
              idx_r   <= 3'd0;
              word_r  <= 32'd0;
              rx_rdy  <= 1'b1;
              state_r <= ST_PAYLOAD;
            end else begin
              state_r <= ST_WAIT_RESP;
`ifdef SSK_ISSUER_TIMEOUT_EN
              tmo_r   <= 16'd0;
`endif
            end
          end
`ifdef SSK_ISSUER_TIMEOUT_EN
          else if (tmo_hit_s) begin
            tx_valid <= 1'b1;
            tx_data  <= STS_TMO;
            state_r  <= ST_STATUS;
          end else begin
            tmo_r <= tmo_r + 16'd1;
          end
`endif
        end

        ST_PAYLOAD: begin
          if (wr_en) begin
            // Word strobe cycle: rx_rdy was low, decide whether more bytes follow.
            if (rem_r == 16'd0) begin
              rx_rdy  <= 1'b0;
              state_r <= ST_WAIT_RESP;
            end else begin
              rx_rdy <= 1'b1;
            end
          end else if (rx_hs_s) begin
            rem_r <= rem_r - 16'd1;
            if ((idx_r[1:0] == 2'd3) || (rem_r == 16'd1)) begin
              wr_en   <= 1'b1;
              wr_data <= word_s;
              word_r  <= 32'd0;
              idx_r   <= 3'd0;
              rx_rdy  <= 1'b0;
            end else begin
              word_r <= word_s;
              idx_r  <= idx_r + 3'd1;
            end
          end else begin
            rx_rdy <= 1'b1;
          end
        end

        ST_WAIT_RESP: begin
          rx_rdy <= 1'b0;
          if (resp_done) begin
            tx_valid <= 1'b1;
            tx_data  <= err_status(resp_err);
            state_r  <= ST_STATUS;
          end
`ifdef SSK_ISSUER_TIMEOUT_EN
          else if (tmo_hit_s) begin
            tx_valid <= 1'b1;
            tx_data  <= STS_TMO;
            state_r  <= ST_STATUS;
          end else begin
            tmo_r <= tmo_r + 16'd1;
          end
`endif
        end

        ST_STATUS: begin
          rx_rdy <= 1'b0;
          if (tx_valid && tx_rdy) begin
            tx_valid <= 1'b0;
            idx_r    <= 3'd0;
            rx_rdy   <= 1'b1;
            state_r  <= ST_HDR;
          end
        end

        default: begin
          rx_rdy   <= 1'b0;
          tx_valid <= 1'b0;
          idx_r    <= 3'd0;
          state_r  <= ST_HDR;
        end
      endcase
    end
  end

endmodule
